instr_mem_loadable: RTL
=======================

// Module: instr_mem_loadable
// PURPOSE
//  Parametrised, run-time loadable instruction memory for the MIPS pipeline, successor to the fixed ROM.
//  Two regions: user (addr[31]=0) and kernel/exception (addr[31]=1); words selected by addr[ADDR_LSB+:log2(DEPTH)].
//  Synchronous 1-cycle fetch read with pipeline stall output.
//  Program images written word-by-word through a loader port (UART/debug) instead of being hard-coded.
//  Self-clears both regions to NOP after reset.
// PARAMETERS
//  USER_DEPTH    256  words in user region (power of 2, >=2)
//  KERNEL_DEPTH  32   words in kernel region (power of 2, >=2)
//  ADDR_LSB      2    byte-to-word shift; address bits below it ignored
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   asynchronous, active-low; clears FSM and output regs
//  fetch_en     in   1   IF stage requests instruction at addr
//  addr         in   32  fetch byte address (PC)
//  instr        out  32  fetched instruction, registered
//  instr_valid  out  1   instr holds fetch result for addr sampled previous cycle
//  addr_err     out  1   registered with instr: word index beyond region depth
//  imem_stall   out  1   IF must hold PC; =1 while not RUN or while a load write is in progress
//  load_we      in   1   loader write strobe, held until load_ack
//  load_addr    in   32  loader byte address (same region/word decode as addr)
//  load_data    in   32  word to write
//  load_ack     out  1   one-cycle pulse: write committed
// BEHAVIOUR
//  Reset values: instr=0, instr_valid=0, addr_err=0, load_ack=0, imem_stall=1, FSM=CLEAR, clr_ptr=0.
//  FSM CLEAR: writes 0 to one user word and one kernel word per cycle at clr_ptr.
//   clr_ptr counts 0..max(USER_DEPTH,KERNEL_DEPTH)-1; kernel writes are suppressed once past KERNEL_DEPTH.
//   Goes to RUN after the last index; load_we and fetch_en ignored (no ack) in CLEAR.
//  FSM RUN: fetch_en=1 -> next cycle instr=mem[region][idx], instr_valid=1.
//   fetch_en=0 -> instr_valid=0; instr holds its last value.
//  Out-of-range idx (any bit between the index field and bit 30 set): instr=0 (NOP), addr_err=1, no memory access.
//  RUN & load_we -> LOAD. LOAD writes load_data at the decoded location, pulses load_ack, returns to RUN.
//   Out-of-range load_addr: write dropped, ack still pulsed.
//   Loader must drop load_we in the ack cycle; load_we seen again afterward starts a new write.
//  Priority: load over fetch. In the RUN cycle that sees load_we, imem_stall=1 combinationally; fetch issues NOP, instr_valid=0.
//  Fetch of the word being written in that same cycle returns the new data (write-first).
//  imem_stall = (state!=RUN) | load_we.
//  Reset asserted mid-CLEAR or mid-LOAD: immediate return to CLEAR, clear restarts from 0.
//   An interrupted write may or may not be committed; it is not acked.
//  Address wrap: only the index field is used; no wrap into the other region.
// CONFIGURATION
//  IMEM_PARITY_EN defined: each word stores an extra even-parity bit, computed on write (CLEAR stores parity of 0).
//   Adds output parity_err (1 bit), registered with instr: set when the read word's parity mismatches.
//   parity_err reset value 0; forced 0 on addr_err/NOP cycles.
//  IMEM_PARITY_EN undefined: no parity storage, no parity_err port; otherwise identical timing.
// TESTING
//  Reset release -> imem_stall=1 for exactly max(USER_DEPTH,KERNEL_DEPTH) cycles, then 0.
//   A fetch of 0x0 and a fetch of 0x80000004 both return 0x00000000.
//  load 0x20010004 @0x0 -> load_ack one cycle later.
//   Then fetch 0x0 -> instr=0x20010004, instr_valid=1 on the next edge.
//  load 0x08000006 @0x80000000, then fetch 0x80000000 -> 0x08000006.
//   Fetch 0x00000000 still returns the user word (region separation).
//  Fetch 0x00000400 with USER_DEPTH=256 -> instr=0, addr_err=1; a following in-range fetch clears addr_err.
//  load_we and fetch_en in the same cycle to the same word -> imem_stall=1, instr_valid=0 that cycle.
//   Refetch returns the new data.
//  Reset pulsed during a LOAD -> no load_ack, CLEAR rerun, word reads 0.
//   With IMEM_PARITY_EN, a bench-forced flipped stored bit -> parity_err=1.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory with a user and a kernel region, self-clearing to NOP after reset.
// Optional per-word even parity and a parity_err output when IMEM_PARITY_EN is defined.
module instr_mem_loadable #(
    parameter int USER_DEPTH   = 256,
    parameter int KERNEL_DEPTH = 32,
    parameter int ADDR_LSB     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [31:0] addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        addr_err,
    output logic        imem_stall,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ack
`ifdef IMEM_PARITY_EN
    ,
    output logic        parity_err
`endif
);

    localparam int UIDX_W    = $clog2(USER_DEPTH);
    localparam int KIDX_W    = $clog2(KERNEL_DEPTH);
    localparam int MAX_DEPTH = (USER_DEPTH > KERNEL_DEPTH) ? USER_DEPTH : KERNEL_DEPTH;
    localparam int CLR_W     = $clog2(MAX_DEPTH);
    localparam int CMPW      = CLR_W + 1;
    localparam logic [CMPW-1:0]  USER_LIM = CMPW'(USER_DEPTH);
    localparam logic [CMPW-1:0]  KERN_LIM = CMPW'(KERNEL_DEPTH);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(MAX_DEPTH - 1);
`ifdef IMEM_PARITY_EN
    localparam int WORD_W = 33;
`else
    localparam int WORD_W = 32;
`endif

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

    // Any set bit between the region's index field and bit 30 means out of range.
    function automatic logic in_range(input logic [31:0] a);
        logic [30:0] hi;
        if (a[31]) hi = a[30:0] >> (ADDR_LSB + KIDX_W);
        else       hi = a[30:0] >> (ADDR_LSB + UIDX_W);
        return hi == '0;
    endfunction

    function automatic logic [WORD_W-1:0] make_word(input logic [31:0] d);
`ifdef IMEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    state_t             state_reg, state_next;
    logic [CLR_W-1:0]   clr_ptr_reg;
    logic [31:0]        ld_addr_reg, ld_data_reg;
    logic [WORD_W-1:0]  user_mem [USER_DEPTH];
    logic [WORD_W-1:0]  kern_mem [KERNEL_DEPTH];
    logic [WORD_W-1:0]  user_rd_reg, kern_rd_reg, rd_word, wdata;
    logic               valid_reg, nop_reg, err_reg, kern_sel_reg, ack_reg;
    logic               run_load, do_fetch, fetch_ok, load_ok;
    logic               user_we, kern_we, user_re, kern_re;
    logic [UIDX_W-1:0]  user_widx;
    logic [KIDX_W-1:0]  kern_widx;

    assign fetch_ok = in_range(addr);
    assign load_ok  = in_range(ld_addr_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_CLEAR;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLEAR: if (clr_ptr_reg == CLR_LAST) state_next = ST_RUN;
            ST_RUN:   if (load_we) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            default:  state_next = ST_CLEAR;
        endcase
    end

    // Reads only happen in RUN without load_we, writes only in CLEAR/LOAD,
    // so a same-cycle read/write collision cannot occur.
    always_comb begin
        imem_stall = (state_reg != ST_RUN) | load_we;
        run_load   = (state_reg == ST_RUN) & load_we;
        do_fetch   = (state_reg == ST_RUN) & ~load_we & fetch_en;
        user_re    = do_fetch & fetch_ok & ~addr[31];
        kern_re    = do_fetch & fetch_ok & addr[31];
        user_we    = 1'b0;
        kern_we    = 1'b0;
        user_widx  = ld_addr_reg[ADDR_LSB +: UIDX_W];
        kern_widx  = ld_addr_reg[ADDR_LSB +: KIDX_W];
        wdata      = make_word(ld_data_reg);
        case (state_reg)
            ST_CLEAR: begin
                user_we   = {1'b0, clr_ptr_reg} < USER_LIM;
                kern_we   = {1'b0, clr_ptr_reg} < KERN_LIM;
                user_widx = clr_ptr_reg[UIDX_W-1:0];
                kern_widx = clr_ptr_reg[KIDX_W-1:0];
                wdata     = '0;
            end
            ST_LOAD: begin
                user_we = load_ok & ~ld_addr_reg[31];
                kern_we = load_ok & ld_addr_reg[31];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) clr_ptr_reg <= '0;
        else if (state_reg == ST_CLEAR) clr_ptr_reg <= clr_ptr_reg + CLR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (run_load) begin
            ld_addr_reg <= load_addr;
            ld_data_reg <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (user_we) user_mem[user_widx] <= wdata;
        if (user_re) user_rd_reg <= user_mem[addr[ADDR_LSB +: UIDX_W]];
    end

    always_ff @(posedge clk) begin
        if (kern_we) kern_mem[kern_widx] <= wdata;
        if (kern_re) kern_rd_reg <= kern_mem[addr[ADDR_LSB +: KIDX_W]];
    end

    // nop_reg forces instr to 0 for reset, out-of-range fetches and load-preempted fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg    <= 1'b0;
            nop_reg      <= 1'b1;
            err_reg      <= 1'b0;
            kern_sel_reg <= 1'b0;
            ack_reg      <= 1'b0;
        end else begin
            valid_reg <= do_fetch;
            ack_reg   <= run_load;
            if (run_load) begin
                nop_reg <= 1'b1;
                err_reg <= 1'b0;
            end else if (do_fetch) begin
                nop_reg      <= ~fetch_ok;
                err_reg      <= ~fetch_ok;
                kern_sel_reg <= addr[31];
            end
        end
    end

    assign rd_word     = kern_sel_reg ? kern_rd_reg : user_rd_reg;
    assign instr       = nop_reg ? 32'h0 : rd_word[31:0];
    assign instr_valid = valid_reg;
    assign addr_err    = err_reg;
    assign load_ack    = ack_reg;
`ifdef IMEM_PARITY_EN
    assign parity_err  = ~nop_reg & (^rd_word);
`endif

endmodule
